// File: rtl/uart_rx_fsm.sv
// UART receiver: 16x oversampled start/8-data/parity/stop frame decoder with a
// 1-deep output register, read handshake and parity/framing/overrun flags.
module uart_rx_fsm #(
    parameter int OVS        = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       rx_in,
    input  logic       rd_enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = $clog2(OVS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic             sync1_q, sync2_q;
    logic             rx_sync;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             busy_q, busy_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             commit;

    assign rx_sync = sync2_q;

    // Next-state logic; the frame walker only moves on rx_enable ticks, while the
    // host-side register (full, overrun, valid pulse) runs every clock.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        full_d  = full_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        commit  = 1'b0;

        if (rx_enable) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_sync) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (rx_sync) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_DATA;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        shift_d[idx_q] = rx_sync;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        par_d   = rx_sync;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Leave mid stop bit so a back-to-back start edge is caught at once.
                    if (cnt_q == CNT_LAST) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (rd_enable && full_q) begin
            full_d = 1'b0;
        end

        if (commit) begin
            data_d  = shift_q;
            perr_d  = par_q ^ (^shift_q) ^ PARITY_ODD;
            ferr_d  = ~rx_sync;
            valid_d = 1'b1;
            full_d  = 1'b1;
            if (full_q && !rd_enable) begin
                ovr_d = 1'b1;
            end
        end
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_full    = full_q;
    assign rx_busy    = busy_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign state_dbg  = state_q;

endmodule
